// File: rtl/morse_pkg.sv
// Shared Morse definitions: frame length, letter table I..P, FSM encoding and decode helper.
package morse_pkg;

  localparam int MORSE_LEN = 13;
  localparam int GAP_UNITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [MORSE_LEN-1:0] pattern_t;

  localparam logic [2:0] LTR_I = 3'd0;
  localparam logic [2:0] LTR_J = 3'd1;
  localparam logic [2:0] LTR_K = 3'd2;
  localparam logic [2:0] LTR_L = 3'd3;
  localparam logic [2:0] LTR_M = 3'd4;
  localparam logic [2:0] LTR_N = 3'd5;
  localparam logic [2:0] LTR_O = 3'd6;
  localparam logic [2:0] LTR_P = 3'd7;

  // Frames are sent LSB first: bit 0 is the first unit on the line.
  localparam pattern_t PAT_I = 13'b0000000000101;
  localparam pattern_t PAT_J = 13'b1110111011101;
  localparam pattern_t PAT_K = 13'b0000111010111;
  localparam pattern_t PAT_L = 13'b0000101011101;
  localparam pattern_t PAT_M = 13'b0000001110111;
  localparam pattern_t PAT_N = 13'b0000000010111;
  localparam pattern_t PAT_O = 13'b0011101110111;
  localparam pattern_t PAT_P = 13'b0010111011101;

  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } decode_t;

  function automatic decode_t decode(input pattern_t pat);
    decode_t r;
    r = '0;
    case (pat)
      PAT_I:   r = '{hit: 1'b1, code: LTR_I};
      PAT_J:   r = '{hit: 1'b1, code: LTR_J};
      PAT_K:   r = '{hit: 1'b1, code: LTR_K};
      PAT_L:   r = '{hit: 1'b1, code: LTR_L};
      PAT_M:   r = '{hit: 1'b1, code: LTR_M};
      PAT_N:   r = '{hit: 1'b1, code: LTR_N};
      PAT_O:   r = '{hit: 1'b1, code: LTR_O};
      PAT_P:   r = '{hit: 1'b1, code: LTR_P};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Reloadable down-counter that holds at zero; zero flag marks the end of a unit interval.
module morse_unit_timer #(
  parameter int WIDTH = 25
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/morse_receiver.sv
// Morse letter receiver: samples the line once per unit mid-bit, decodes I..P or flags an error.
// Optional glitch filter on the synchronised line when MORSE_RX_FILTER_EN is defined.
module morse_receiver
  import morse_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 25000000,
  parameter int FILTER_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_error,
  output logic       busy
);

  localparam int TW = $clog2(TICKS_PER_UNIT);
  localparam logic [TW-1:0] HALF_LOAD = TW'(TICKS_PER_UNIT / 2 - 1);
  localparam logic [TW-1:0] UNIT_LOAD = TW'(TICKS_PER_UNIT - 1);

  if ((TICKS_PER_UNIT < 4) || (TICKS_PER_UNIT % 2 != 0) || (FILTER_CYCLES < 1)) begin : g_param_check
    $error("morse_receiver: TICKS_PER_UNIT must be even and >= 4, FILTER_CYCLES >= 1");
  end

  logic [1:0] sync_q, sync_d;
  logic       line_lvl;
  logic       line_prev_q;
  logic       rise;

  assign sync_d = {sync_q[0], morse_in};

`ifdef MORSE_RX_FILTER_EN
  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;

  // Level follows the synchronised line only after it has held a new value long enough.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync_q[1] != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_CYCLES - 1)) begin
        filt_d = sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign line_lvl = filt_q;
`else
  assign line_lvl = sync_q[1];
`endif

  assign rise = line_lvl & ~line_prev_q;

  state_t         state_q, state_d;
  pattern_t       shift_q, shift_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]     zrun_q, zrun_d;
  logic [2:0]     letter_q, letter_d;
  logic           valid_q, valid_d;
  logic           error_q, error_d;
  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_zero;
  decode_t        dec;

  morse_unit_timer #(.WIDTH(TW)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    zrun_d    = zrun_q;
    letter_d  = letter_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = UNIT_LOAD;
    dec       = '0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_RECV;
          tmr_load  = 1'b1;
          tmr_val   = HALF_LOAD;
          shift_d   = '0;
          bit_cnt_d = '0;
          zrun_d    = '0;
        end
      end
      ST_RECV: begin
        if (tmr_zero) begin
          shift_d[bit_cnt_q] = line_lvl;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          zrun_d             = line_lvl ? 2'd0 : zrun_q + 1'b1;
          tmr_load           = 1'b1;
          if ((bit_cnt_q == 4'd0) && !line_lvl) begin
            state_d = ST_IDLE;
          end else if ((zrun_d == 2'(GAP_UNITS)) || (bit_cnt_d == 4'(MORSE_LEN))) begin
            // Result is registered here so the pulse and the new letter appear together in DONE.
            state_d = ST_DONE;
            dec     = decode(shift_d);
            if (dec.hit) begin
              letter_d = dec.code;
              valid_d  = 1'b1;
            end else begin
              error_d  = 1'b1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q      <= '0;
      line_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      zrun_q      <= '0;
      letter_q    <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      line_prev_q <= line_lvl;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      zrun_q      <= zrun_d;
      letter_q    <= letter_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = valid_q;
  assign letter_error = error_q;
  assign busy         = (state_q == ST_RECV);

endmodule

// File: tb/tb_morse_receiver.sv
// Bench for morse_receiver: table of letter frames plus hand sequences, pulses checked via a scoreboard.
module tb_morse_receiver;

  localparam int TPU = 8;
  localparam int FC  = 2;
`ifdef MORSE_RX_FILTER_EN
  localparam int LAT_OFF = FC;
`else
  localparam int LAT_OFF = 0;
`endif

  logic       clock;
  logic       reset_n;
  logic       morse_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_error;
  logic       busy;

  morse_receiver #(.TICKS_PER_UNIT(TPU), .FILTER_CYCLES(FC)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .morse_in     (morse_in),
    .letter       (letter),
    .letter_valid (letter_valid),
    .letter_error (letter_error),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       err;
    logic [2:0] letter;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [12:0] pat;
    logic        exp_err;
    logic [2:0]  exp_letter;
  } vec_t;

  exp_t       sbq[$];
  vec_t       vecs[12];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       prev_pulse = 1'b0;
  logic [2:0] model_letter = 3'd0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance one clock; outputs are observed on the falling edge.
  task automatic tick();
    exp_t e;
    logic pulse;
    @(negedge clock);
    cyc++;
    pulse = letter_valid | letter_error;
    if (pulse) begin
      chk("both_pulses", int'(letter_valid & letter_error), 0);
      chk("pulse_width", int'(prev_pulse), 0);
      chk("busy_at_pulse", int'(busy), 0);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("pulse_kind_error", int'(letter_error), int'(e.err));
        chk("letter", int'(letter), int'(e.letter));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
    prev_pulse = pulse;
  endtask

  // Index of the sample that closes the frame, or -1 for a false start.
  function automatic int frame_end(input logic [12:0] p);
    int zr;
    zr = 0;
    if (!p[0]) return -1;
    for (int k = 0; k < 13; k++) begin
      zr = p[k] ? 0 : zr + 1;
      if (zr == 3) return k;
    end
    return 12;
  endfunction

  task automatic expect_frame(input logic [12:0] p, input logic err, input logic [2:0] ltr);
    exp_t e;
    int   k;
    k = frame_end(p);
    if (k >= 0) begin
      e.err    = err;
      e.letter = err ? model_letter : ltr;
      e.cyc    = cyc + 7 + TPU * k + LAT_OFF;
      sbq.push_back(e);
      if (!err) model_letter = ltr;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", sbq.size(), 0);
    sbq.delete();
    repeat (10) tick();
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic send(input logic [12:0] p, input logic err, input logic [2:0] ltr, input int glitch_unit);
    expect_frame(p, err, ltr);
    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < TPU; j++) begin
        morse_in = (i == glitch_unit && j == 1) ? ~p[i] : p[i];
        tick();
      end
    end
    morse_in = 1'b0;
    drain();
  endtask

  initial begin
    int   busy_cnt;
    logic seen_busy;

    vecs[0]  = '{13'b0000000000101, 1'b0, 3'd0};
    vecs[1]  = '{13'b1110111011101, 1'b0, 3'd1};
    vecs[2]  = '{13'b0000111010111, 1'b0, 3'd2};
    vecs[3]  = '{13'b0000101011101, 1'b0, 3'd3};
    vecs[4]  = '{13'b0000001110111, 1'b0, 3'd4};
    vecs[5]  = '{13'b0000000010111, 1'b0, 3'd5};
    vecs[6]  = '{13'b0011101110111, 1'b0, 3'd6};
    vecs[7]  = '{13'b0010111011101, 1'b0, 3'd7};
    vecs[8]  = '{13'b0000000000111, 1'b1, 3'd0};
    vecs[9]  = '{13'b0000000000001, 1'b1, 3'd0};
    vecs[10] = '{13'b0000000001101, 1'b1, 3'd0};
    vecs[11] = '{13'b0000101011101, 1'b0, 3'd3};

    reset_n  = 1'b0;
    morse_in = 1'b0;
    repeat (3) tick();
    chk("reset_letter", int'(letter), 0);
    chk("reset_valid", int'(letter_valid), 0);
    chk("reset_error", int'(letter_error), 0);
    chk("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (3) tick();

    for (int v = 0; v < 12; v++) begin
      send(vecs[v].pat, vecs[v].exp_err, vecs[v].exp_letter, -1);
    end

    // Full 13-unit frame with the line left high: must not restart without a new edge.
    expect_frame(13'b1111111111111, 1'b1, 3'd0);
    morse_in = 1'b1;
    repeat (13 * TPU + 10) tick();
    busy_cnt = 0;
    repeat (50) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("no_restart_while_high", busy_cnt, 0);
    morse_in = 1'b0;
    drain();

    // Short high glitch in idle: false start, no pulse.
    seen_busy = 1'b0;
    morse_in  = 1'b1;
    repeat (2) tick();
    morse_in = 1'b0;
    repeat (30) begin
      tick();
      seen_busy |= busy;
    end
    chk("glitch_busy_seen", int'(seen_busy), 1);
    chk("glitch_busy_drop", int'(busy), 0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 5 * TPU; i++) begin
      morse_in = vecs[6].pat[i / TPU];
      tick();
    end
    chk("midframe_busy", int'(busy), 1);
    reset_n  = 1'b0;
    morse_in = 1'b0;
    tick();
    chk("midreset_letter", int'(letter), 0);
    chk("midreset_valid", int'(letter_valid), 0);
    chk("midreset_error", int'(letter_error), 0);
    chk("midreset_busy", int'(busy), 0);
    reset_n      = 1'b1;
    model_letter = 3'd0;
    sbq.delete();
    repeat (5) tick();
    send(13'b0000101011101, 1'b0, 3'd3, -1);

    // One-clock low glitch inside the first dash of M.
    send(13'b0000001110111, 1'b0, 3'd4, 1);
    chk("final_letter", int'(letter), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
